// File: rtl/wrr_burst_scheduler_if.sv
// Handshake bundle between the requester bank / downstream port and the
// weighted round-robin burst scheduler.
interface wrr_burst_scheduler_if #(
  parameter int N  = 8,
  parameter int WW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    request;
  logic [N*WW-1:0] weight;
  logic            ready;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            grant_valid;
  logic            stall;

  // Requester bank / downstream side: drives requests, weights and ready.
  modport master (
    output request, weight, ready,
    input  grant, grant_id, grant_valid, stall
  );

  // Scheduler side.
  modport slave (
    input  request, weight, ready,
    output grant, grant_id, grant_valid, stall
  );
endinterface

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin burst scheduler: the winning requester keeps the
// grant for up to weight[i] accepted beats, then the grant rotates with no
// idle cycle. Back-pressure holds the grant; dropping a request releases it.
module wrr_burst_scheduler #(
  parameter int N  = 8,
  parameter int WW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  wrr_burst_scheduler_if.slave    bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [WW-1:0]   credit_q, credit_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            grant_valid;
  logic            beat;
  logic            release_now;
  logic [IW-1:0]   pick_base;
  logic [IW:0]     pick_res;
  logic            pick_found;
  logic [IW-1:0]   pick_id;

  // First set request bit strictly after 'last', wrapping modulo N.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [IW:0] pick_next(input logic [N-1:0]  req,
                                            input logic [IW-1:0] last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  // Burst quota for a requester; a zero weight still earns one beat.
  function automatic logic [WW-1:0] quota(input logic [N*WW-1:0] w,
                                          input logic [IW-1:0]   id);
    logic [WW-1:0] q;
    q = w[int'(id)*WW +: WW];
    return (q == '0) ? WW'(1) : q;
  endfunction

  assign grant_valid = |grant_q;
  assign beat        = grant_valid & bus.ready;
  // Release on the final beat of the burst, or when the holder withdraws
  // its request on a cycle that moved no data.
  assign release_now = (beat && (credit_q == WW'(1))) ||
                       (!bus.request[grant_id_q] && !beat);
  // On release the search starts after the current holder, which makes the
  // releasing requester lowest priority; in IDLE it starts after ptr.
  assign pick_base   = (state_q == SERVE) ? grant_id_q : ptr_q;
  assign pick_res    = pick_next(bus.request, pick_base);
  assign pick_found  = pick_res[IW];
  assign pick_id     = pick_res[IW-1:0];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      credit_q   <= '0;
      ptr_q      <= IW'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      credit_q   <= credit_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = SERVE;
      SERVE:   if (release_now && !pick_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of grant, grant_id, credit and ptr.
  always_comb begin
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    credit_d   = credit_q;
    ptr_d      = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          credit_d         = quota(bus.weight, pick_id);
        end
      end
      SERVE: begin
        if (release_now) begin
          ptr_d = grant_id_q;
          if (pick_found) begin
            grant_d          = '0;
            grant_d[pick_id] = 1'b1;
            grant_id_d       = pick_id;
            credit_d         = quota(bus.weight, pick_id);
          end else begin
            grant_d    = '0;
            grant_id_d = '0;
            credit_d   = '0;
          end
        end else if (beat && (credit_q > WW'(1))) begin
          credit_d = credit_q - WW'(1);
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        credit_d   = '0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid;
  assign bus.stall       = (grant_valid & ~bus.ready) |
                           ((|bus.request) & ~grant_valid);

endmodule
